// File: rtl/ripple_carry_16bit.sv
// Registered ripple-carry adder: {c_out, s} = a + b + c_in, with signed overflow.
// One full-adder cell per bit; the carry chain runs from bit 0 to bit WIDTH-1.
module ripple_carry_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] sum;
  logic             ovf_next;

  assign c[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign p[i]   = a[i] ^ b[i];
    assign g[i]   = a[i] & b[i];
    assign sum[i] = p[i] ^ c[i];
    assign c[i+1] = g[i] | (p[i] & c[i]);
  end

  // Carries into and out of the sign bit disagree only on signed overflow.
  assign ovf_next = c[WIDTH] ^ c[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s         <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s     <= sum;
        c_out <= c[WIDTH];
        ovf   <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_ripple_carry_16bit.sv
// Bench for ripple_carry_16bit: directed vectors plus a random back-to-back run,
// checked through an expected-result queue drained by an output monitor.
module tb_ripple_carry_16bit;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        in_valid;
  logic [15:0] s;
  logic        c_out;
  logic        ovf;
  logic        out_valid;

  int checks;
  int errors;

  // Packed expectation: {c_out, ovf, s}
  logic [17:0] sb[$];

  ripple_carry_16bit #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .in_valid (in_valid),
    .s        (s),
    .c_out    (c_out),
    .ovf      (ovf),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] ref_model(input logic [15:0] x,
                                            input logic [15:0] y,
                                            input logic ci);
    logic [16:0] full;
    logic        v;
    full = {1'b0, x} + {1'b0, y} + {16'd0, ci};
    v    = (x[15] == y[15]) && (full[15] != x[15]);
    return {full[16], v, full[15:0]};
  endfunction

  // Issue one operation; the next rising edge samples it.
  task automatic issue(input logic [15:0] x, input logic [15:0] y,
                       input logic ci, input logic [17:0] exp);
    @(posedge clk);
    #1;
    a        = x;
    b        = y;
    c_in     = ci;
    in_valid = 1'b1;
    sb.push_back(exp);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    check("drain_queue_empty", sb.size(), 0);
  endtask

  // Monitor: every valid output pops one expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got s=0x%0h with empty queue", s);
      end else begin
        logic [17:0] e;
        e = sb.pop_front();
        check("result", {14'd0, c_out, ovf, s}, {14'd0, e});
      end
    end
  end

  logic [15:0] ra;
  logic [15:0] rb;
  logic        rc;

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    a        = 16'h0;
    b        = 16'h0;
    c_in     = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // First op after release; result one cycle later.
    issue(16'hF0F1, 16'hCA3F, 1'b0, {1'b1, 1'b0, 16'hBB30});
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("first_latency_valid", {31'd0, out_valid}, 1);
    check("first_latency_s", {16'd0, s}, 32'h0000BB30);
    drain();

    // Load a nonzero result, then reset asynchronously mid-cycle.
    issue(16'h9C9D, 16'h8FF0, 1'b0, {1'b1, 1'b1, 16'h2C8D});
    @(posedge clk);
    #2;
    a        = 16'hFFFF;
    b        = 16'hFFFF;
    c_in     = 1'b1;
    in_valid = 1'b1;
    rst_n    = 1'b0;
    #1;
    check("reset_s", {16'd0, s}, 0);
    check("reset_flags", {29'd0, c_out, ovf, out_valid}, 0);
    sb.delete();
    @(posedge clk);
    #1;
    check("reset_hold_valid", {31'd0, out_valid}, 0);
    in_valid = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 check("post_release_idle", {31'd0, out_valid}, 0);

    // Directed vectors, back to back.
    issue(16'hF0F1, 16'hCA3F, 1'b0, {1'b1, 1'b0, 16'hBB30});
    issue(16'h9C9D, 16'h8FF0, 1'b0, {1'b1, 1'b1, 16'h2C8D});
    issue(16'hFFFF, 16'hFFFF, 1'b0, {1'b1, 1'b0, 16'hFFFE});
    issue(16'hFFFF, 16'hFFFF, 1'b1, {1'b1, 1'b0, 16'hFFFF});
    issue(16'hAAAA, 16'h5555, 1'b0, {1'b0, 1'b0, 16'hFFFF});
    issue(16'hAAAA, 16'h5555, 1'b1, {1'b1, 1'b0, 16'h0000});
    issue(16'h7FFF, 16'h0000, 1'b1, {1'b0, 1'b1, 16'h8000});
    issue(16'h009D, 16'h800F, 1'b0, {1'b0, 1'b0, 16'h80AC});

    // Hold: in_valid low with new operands.
    @(posedge clk);
    #1;
    a        = 16'h1234;
    b        = 16'h4321;
    c_in     = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("hold_valid", {31'd0, out_valid}, 0);
    check("hold_s", {16'd0, s}, 32'h000080AC);
    check("hold_flags", {30'd0, c_out, ovf}, 0);
    drain();

    // Random back-to-back.
    for (int i = 0; i < 10000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      issue(ra, rb, rc, ref_model(ra, rb, rc));
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
